aes_state_packer: RTL and testbench

//  Collects column words from LANES parallel ALUs over several beats into one full AES state block.

---
 rtl/aes_state_packer.sv | 135 +++++++++++++
 tb/tb_aes_state_packer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_state_packer.sv
// Gathers LANES column words per beat into a full AES state, emitting it column- or row-major.
// One cycle from final beat to out_valid; only the final beat stalls, and only while the output buffer is held.
module aes_state_packer #(
   parameter int LANES = 2,
   parameter int COLS  = 4,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [32*LANES-1:0]   alu_results,
   input  logic                  mc_mode,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [32*COLS-1:0]    out_state,
   output logic                  out_mode,
   output logic [CNT_W-1:0]      blk_cnt
);
   localparam int BEATS   = COLS / LANES;
   localparam int STATE_W = 32 * COLS;
   localparam int BC_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

   generate
      if (COLS % LANES != 0) begin : g_bad_cfg
         $error("aes_state_packer: COLS must be a multiple of LANES");
      end
   endgenerate

   logic [BC_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [31:0]        fill_q [COLS];
   logic [31:0]        fill_d [COLS];
   logic               mode_q, mode_d;
   logic               out_valid_q, out_valid_d;
   logic [STATE_W-1:0] out_state_q, out_state_d;
   logic               out_mode_q, out_mode_d;
   logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

   logic [31:0]        cols [COLS];
   logic [STATE_W-1:0] packed_blk;
   logic               is_final;
   logic               take;
   logic               drain;
   logic               blk_mode;

   always_comb begin
      is_final = (beat_cnt_q == BC_W'(BEATS - 1));
      in_ready = !flush && (!is_final || !out_valid_q || out_ready);
      take     = in_valid && in_ready;
      drain    = out_valid_q && out_ready;
      // A single-beat block has no earlier beat to latch the mode from.
      blk_mode = (beat_cnt_q == '0) ? mc_mode : mode_q;

      // Current lanes overlay the columns belonging to this beat.
      for (int c = 0; c < COLS; c++) begin
         if (c / LANES == int'(beat_cnt_q)) begin
            cols[c] = alu_results[32*(c % LANES) +: 32];
         end else begin
            cols[c] = fill_q[c];
         end
      end

      packed_blk = '0;
      if (blk_mode) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < COLS; c++) begin
               packed_blk[STATE_W-1-8*(r*COLS+c) -: 8] = cols[c][31-8*r -: 8];
            end
         end
      end else begin
         for (int c = 0; c < COLS; c++) begin
            packed_blk[STATE_W-1-32*c -: 32] = cols[c];
         end
      end

      beat_cnt_d  = beat_cnt_q;
      fill_d      = fill_q;
      mode_d      = mode_q;
      out_valid_d = out_valid_q;
      out_state_d = out_state_q;
      out_mode_d  = out_mode_q;
      blk_cnt_d   = blk_cnt_q;

      if (drain) begin
         out_valid_d = 1'b0;
         blk_cnt_d   = blk_cnt_q + CNT_W'(1);
      end

      if (flush) begin
         beat_cnt_d = '0;
      end else if (take) begin
         if (is_final) begin
            beat_cnt_d  = '0;
            out_state_d = packed_blk;
            out_mode_d  = blk_mode;
            out_valid_d = 1'b1;
         end else begin
            fill_d     = cols;
            beat_cnt_d = beat_cnt_q + BC_W'(1);
            if (beat_cnt_q == '0) begin
               mode_d = mc_mode;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_q  <= '0;
         for (int c = 0; c < COLS; c++) begin
            fill_q[c] <= '0;
         end
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_state_q <= '0;
         out_mode_q  <= 1'b0;
         blk_cnt_q   <= '0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         fill_q      <= fill_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_state_q <= out_state_d;
         out_mode_q  <= out_mode_d;
         blk_cnt_q   <= blk_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_state = out_state_q;
   assign out_mode  = out_mode_q;
   assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_aes_state_packer.sv
// Bench for aes_state_packer: vector table, directed stall/flush/reset sequences,
// a single-beat configuration, and a randomized run against a queue-based model.
module tb_aes_state_packer;

   logic         clk;
   logic         rst;
   logic         in_valid, in_ready, mc_mode, flush, out_valid, out_ready, out_mode;
   logic [63:0]  alu_results;
   logic [127:0] out_state;
   logic [15:0]  blk_cnt;

   logic         in_valid4, in_ready4, mc_mode4, flush4, out_valid4, out_ready4, out_mode4;
   logic [127:0] alu_results4;
   logic [127:0] out_state4;
   logic [1:0]   blk_cnt4;

   int tests = 0;
   int fails = 0;

   aes_state_packer #(.LANES(2), .COLS(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_results(alu_results), .mc_mode(mc_mode), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
      .out_mode(out_mode), .blk_cnt(blk_cnt)
   );

   aes_state_packer #(.LANES(4), .COLS(4), .CNT_W(2)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .alu_results(alu_results4), .mc_mode(mc_mode4), .flush(flush4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_state(out_state4),
      .out_mode(out_mode4), .blk_cnt(blk_cnt4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [31:0]  w[4];
      logic         m0, m1;
      logic [127:0] exp_s;
      logic         exp_m;
   } vec_t;

   typedef struct packed {
      logic [127:0] s;
      logic         m;
   } blk_t;

   // Reference: a 4x4 byte matrix read out column-by-column or row-by-row.
   function automatic logic [127:0] pack(input logic [31:0] w0, w1, w2, w3, input logic m);
      logic [31:0]  w[4];
      logic [7:0]   byt[4][4];
      logic [127:0] res;
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            byt[c][r] = 8'((w[c] >> (24 - 8*r)) & 32'hFF);
      res = '0;
      if (m) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               res = (res << 8) | {120'd0, byt[c][r]};
      end else begin
         for (int c = 0; c < 4; c++)
            res = (res << 32) | {96'd0, w[c]};
      end
      return res;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Present one beat from a negedge and hold it until accepted; returns on the negedge after acceptance.
   task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic m);
      bit ok;
      ok = 0;
      in_valid = 1'b1;
      alu_results = {b, a};
      mc_mode = m;
      for (int t = 0; t < 20 && !ok; t++) begin
         #1;
         if (in_ready) ok = 1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL beat_accept: in_ready stayed 0, want a handshake within 20 cycles");
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; mc_mode = 1'b0; alu_results = '0;
      in_valid4 = 1'b0; flush4 = 1'b0; out_ready4 = 1'b0; mc_mode4 = 1'b0; alu_results4 = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t tbl[6];
   blk_t pend[$];

   initial begin
      logic [31:0] pw[4];
      logic [31:0] rw[4];
      int          part_n;
      logic        part_m;
      logic [15:0] exp_cnt;
      logic [1:0]  exp_cnt4;
      logic        exp_v4;
      logic [127:0] exp_s4;
      logic        exp_m4;
      logic        exp_rdy, drain, m;

      tbl[0].w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
      tbl[0].m0 = 1; tbl[0].m1 = 1; tbl[0].exp_s = 128'h004488CC_115599DD_2266AAEE_3377BBFF; tbl[0].exp_m = 1;
      tbl[1].w = tbl[0].w;
      tbl[1].m0 = 0; tbl[1].m1 = 0; tbl[1].exp_s = 128'h00112233_44556677_8899AABB_CCDDEEFF; tbl[1].exp_m = 0;
      tbl[2].w = tbl[0].w;
      tbl[2].m0 = 1; tbl[2].m1 = 0; tbl[2].exp_s = 128'h004488CC_115599DD_2266AAEE_3377BBFF; tbl[2].exp_m = 1;
      tbl[3].w = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
      tbl[3].m0 = 1; tbl[3].m1 = 1; tbl[3].exp_s = 128'h0105090D_02060A0E_03070B0F_04080C10; tbl[3].exp_m = 1;
      tbl[4].w = tbl[3].w;
      tbl[4].m0 = 0; tbl[4].m1 = 1; tbl[4].exp_s = 128'h01020304_05060708_090A0B0C_0D0E0F10; tbl[4].exp_m = 0;
      tbl[5].w = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
      tbl[5].m0 = 1; tbl[5].m1 = 1; tbl[5].exp_s = 128'hFF00FF00_FF00FF00_FF00FF00_FF00FF00; tbl[5].exp_m = 1;

      // Reset state
      do_reset();
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_state", out_state, 0);
      chk("rst_out_mode", out_mode, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst4_out_valid", out_valid4, 0);
      chk("rst4_blk_cnt", blk_cnt4, 0);
      @(negedge clk);

      // Vector table, output always drained
      out_ready = 1'b1;
      foreach (tbl[i]) begin
         beat(tbl[i].w[0], tbl[i].w[1], tbl[i].m0);
         beat(tbl[i].w[2], tbl[i].w[3], tbl[i].m1);
         #1;
         chk($sformatf("tbl%0d_valid", i), out_valid, 1);
         chk($sformatf("tbl%0d_state", i), out_state, tbl[i].exp_s);
         chk($sformatf("tbl%0d_mode", i), out_mode, tbl[i].exp_m);
      end
      @(negedge clk);
      #1;
      chk("tbl_blk_cnt", blk_cnt, 6);
      chk("tbl_drained", out_valid, 0);

      // Backpressure: block B stalls on its final beat until A drains
      do_reset();
      beat(32'h00112233, 32'h44556677, 1);
      beat(32'h8899AABB, 32'hCCDDEEFF, 1);
      #1;
      chk("bp_A_state", out_state, 128'h004488CC_115599DD_2266AAEE_3377BBFF);
      @(negedge clk);
      beat(32'hDEADBEEF, 32'hCAFEF00D, 0);
      in_valid = 1'b1; alu_results = {32'h0BADF00D, 32'h12345678}; mc_mode = 1'b1;
      #1;
      chk("bp_final_stall", in_ready, 0);
      @(negedge clk);
      #1;
      chk("bp_final_stall2", in_ready, 0);
      chk("bp_A_intact", out_state, 128'h004488CC_115599DD_2266AAEE_3377BBFF);
      chk("bp_blk_cnt0", blk_cnt, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      #1;
      chk("bp_blk_cnt1", blk_cnt, 1);
      chk("bp_valid", out_valid, 1);
      chk("bp_B_state", out_state, pack(32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h0BADF00D, 0));
      chk("bp_B_mode", out_mode, 0);

      // Flush discards a partial block while a pending block stays put
      do_reset();
      beat(32'h11111111, 32'h22222222, 0);
      beat(32'h33333333, 32'h44444444, 0);
      beat(32'hAAAAAAAA, 32'hBBBBBBBB, 0);
      in_valid = 1'b1; flush = 1'b1; alu_results = {32'hCCCCCCCC, 32'hDDDDDDDD};
      #1;
      chk("fl_in_ready", in_ready, 0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("fl_pending", out_state, 128'h11111111_22222222_33333333_44444444);
      @(negedge clk);
      beat(32'h01020304, 32'h05060708, 1);
      in_valid = 1'b1; alu_results = {32'h0D0E0F10, 32'h090A0B0C}; mc_mode = 1'b0;
      #1;
      chk("fl_final_stall", in_ready, 0);
      chk("fl_pending2", out_state, 128'h11111111_22222222_33333333_44444444);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      #1;
      chk("fl_fresh_state", out_state, 128'h0105090D_02060A0E_03070B0F_04080C10);
      chk("fl_fresh_mode", out_mode, 1);
      chk("fl_blk_cnt", blk_cnt, 1);

      // Asynchronous reset while mid-block and mid-stall
      do_reset();
      beat(32'h11111111, 32'h22222222, 1);
      beat(32'h33333333, 32'h44444444, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      beat(32'h55555555, 32'h66666666, 1);
      beat(32'h77777777, 32'h88888888, 1);
      beat(32'h99999999, 32'hAAAAAAAA, 0);
      in_valid = 1'b1; alu_results = {32'hCCCCCCCC, 32'hBBBBBBBB};
      #2;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_out_state", out_state, 0);
      chk("ar_out_mode", out_mode, 0);
      chk("ar_blk_cnt", blk_cnt, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      beat(32'h00112233, 32'h44556677, 0);
      beat(32'h8899AABB, 32'hCCDDEEFF, 0);
      #1;
      chk("ar_fresh_state", out_state, 128'h00112233_44556677_8899AABB_CCDDEEFF);

      // Single-beat configuration: one block per cycle, 2-bit counter wraps
      do_reset();
      in_valid4 = 1'b1; out_ready4 = 1'b1;
      exp_v4 = 0; exp_cnt4 = 0; exp_s4 = '0; exp_m4 = 0;
      for (int i = 0; i < 12; i++) begin
         for (int c = 0; c < 4; c++) rw[c] = $urandom();
         m = 1'($urandom_range(0, 1));
         alu_results4 = {rw[3], rw[2], rw[1], rw[0]};
         mc_mode4 = m;
         #1;
         chk("b1_in_ready", in_ready4, 1);
         chk("b1_valid", out_valid4, exp_v4);
         chk("b1_blk_cnt", blk_cnt4, exp_cnt4);
         if (exp_v4) begin
            chk("b1_state", out_state4, exp_s4);
            chk("b1_mode", out_mode4, exp_m4);
            exp_cnt4 = exp_cnt4 + 2'd1;
         end
         exp_v4 = 1; exp_s4 = pack(rw[0], rw[1], rw[2], rw[3], m); exp_m4 = m;
         @(negedge clk);
      end
      in_valid4 = 1'b0;

      // Randomized run against the scoreboard
      do_reset();
      part_n = 0; part_m = 0; exp_cnt = 0;
      pend.delete();
      for (int cyc = 0; cyc < 800; cyc++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         flush = ($urandom_range(0, 11) == 0);
         out_ready = 1'($urandom_range(0, 1));
         mc_mode = 1'($urandom_range(0, 1));
         rw[0] = $urandom(); rw[1] = $urandom();
         alu_results = {rw[1], rw[0]};
         #1;
         exp_rdy = !flush && (part_n != 2 || pend.size() == 0 || out_ready);
         chk("rnd_in_ready", in_ready, exp_rdy);
         chk("rnd_out_valid", out_valid, pend.size() != 0);
         chk("rnd_blk_cnt", blk_cnt, exp_cnt);
         drain = (pend.size() != 0) && out_ready;
         if (drain) begin
            chk("rnd_state", out_state, pend[0].s);
            chk("rnd_mode", out_mode, pend[0].m);
            void'(pend.pop_front());
            exp_cnt = exp_cnt + 16'd1;
         end
         if (flush) begin
            part_n = 0;
         end else if (in_valid && exp_rdy) begin
            if (part_n == 0) part_m = mc_mode;
            pw[part_n] = rw[0];
            pw[part_n + 1] = rw[1];
            part_n += 2;
            if (part_n == 4) begin
               pend.push_back('{s: pack(pw[0], pw[1], pw[2], pw[3], part_m), m: part_m});
               part_n = 0;
            end
         end
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
